// File: rtl/iter_div_pkg.sv
// Shared encodings, counter sizing and result layout for the iterative divider.
// Latency: none (types and constants only).
// Backpressure: none (no datapath in this file).
//
// The result layout macro is also what the EXE-stage result mux assumes:
// quotient in the upper half, remainder in the lower half.

`ifndef ITER_DIV_DOUT
`define ITER_DIV_DOUT(quo, rem) {(quo), (rem)}
`endif

package iter_div_pkg;

   // Divider sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   // Operand width of the standard core build.
   localparam int DIV_WIDTH_DFLT = 32;

   // Bits needed for a counter running WIDTH-1 down to 0.
   function automatic int div_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH_DFLT);

endpackage

// File: rtl/iter_div_sign_fix.sv
// Two-lane conditional two's-complement negate; used as |x| on operand prep
// and as the sign fix-up on the quotient/remainder.
// Latency: combinational. Backpressure: none (pure function of its inputs).
//
// Ports:
//   x_in, y_in   : lane inputs
//   neg_x, neg_y : negate the matching lane when high
//   x_out, y_out : lane outputs
// For absolute value the caller drives neg_* with the operand's sign bit; the
// most negative value maps to itself, which read as unsigned is 2^(WIDTH-1).

module div_sign_fix
   import iter_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DFLT
) (
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic             neg_x,
   input  logic             neg_y,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out
);

   assign x_out = neg_x ? (-x_in) : x_in;
   assign y_out = neg_y ? (-y_in) : y_in;

endmodule

// File: rtl/iter_div.sv
// Radix-2 restoring divider answering the EXE-stage divide handshake.
// Latency: last operand handshake at edge T -> dout_tvalid in the cycle after edge T+WIDTH+1.
// Backpressure: per-channel tready low from capture until the result strobe; output has none.
//
// Ports:
//   clk, resetn            : clock (rising edge), asynchronous active-low reset
//   flush                  : abandon any operation, drop captured operands
//   s_axis_dividend_*      : dividend valid/ready channel
//   s_axis_divisor_*       : divisor valid/ready channel
//   m_axis_dout_tdata      : {quotient, remainder}, held until the next result
//   m_axis_dout_tvalid     : one-cycle result strobe
//
// SIGNED selects two's-complement (truncating) division; otherwise unsigned.

module iter_div
   import iter_div_pkg::*;
#(
   parameter int WIDTH  = DIV_WIDTH_DFLT,
   parameter bit SIGNED = 1'b0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               flush,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tvalid
);

   // The standard build shares the counter width with the rest of the core.
   localparam int CNT_W = (WIDTH == DIV_WIDTH_DFLT) ? DIV_CNT_W : div_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   div_state_e         state_q,    state_d;
   logic               dvd_flg_q,  dvd_flg_d;   // dividend captured
   logic               dvs_flg_q,  dvs_flg_d;   // divisor captured
   logic [WIDTH-1:0]   dvd_q,      dvd_d;       // raw captured dividend
   logic [WIDTH-1:0]   dvs_q,      dvs_d;       // raw captured divisor
   logic [WIDTH-1:0]   div_q,      div_d;       // divisor magnitude used by the loop
   logic [WIDTH-1:0]   rem_q,      rem_d;       // partial remainder
   logic [WIDTH-1:0]   quo_q,      quo_d;       // dividend bits shifting out / quotient bits in
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               quo_neg_q,  quo_neg_d;
   logic               rem_neg_q,  rem_neg_d;
   logic [2*WIDTH-1:0] dout_dat_q, dout_dat_d;
   logic               dout_vld_q, dout_vld_d;

   // ---------------------------------------------------------------------
   // Input capture
   // ---------------------------------------------------------------------
   logic dvd_rdy, dvs_rdy;
   logic dvd_hs,  dvs_hs;
   logic start;

   assign dvd_rdy = (state_q == ST_IDLE) && !dvd_flg_q;
   assign dvs_rdy = (state_q == ST_IDLE) && !dvs_flg_q;
   assign dvd_hs  = s_axis_dividend_tvalid && dvd_rdy;
   assign dvs_hs  = s_axis_divisor_tvalid  && dvs_rdy;

   // Both operands are present either from an earlier capture or from a
   // handshake at this very edge.
   assign start = (state_q == ST_IDLE) && (dvd_flg_q || dvd_hs) && (dvs_flg_q || dvs_hs);

   // Operand values for prep: the latched copy if already captured, otherwise
   // the bus value arriving with this edge's handshake.
   logic [WIDTH-1:0] a_raw, b_raw;
   logic             a_sgn, b_sgn;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_raw = dvd_flg_q ? dvd_q : s_axis_dividend_tdata;
   assign b_raw = dvs_flg_q ? dvs_q : s_axis_divisor_tdata;
   assign a_sgn = SIGNED && a_raw[WIDTH-1];
   assign b_sgn = SIGNED && b_raw[WIDTH-1];

   div_sign_fix #(.WIDTH(WIDTH)) u_prep (
      .x_in  (a_raw),
      .y_in  (b_raw),
      .neg_x (a_sgn),
      .neg_y (b_sgn),
      .x_out (a_mag),
      .y_out (b_mag)
   );

   // ---------------------------------------------------------------------
   // One restoring step per cycle
   // ---------------------------------------------------------------------
   // rem is kept one bit wider during the trial so that a shifted remainder
   // up to 2*divisor-1 never overflows; the top bit of the difference is
   // the borrow.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic [WIDTH-1:0] quo_fx, rem_fx;

   assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
   assign trial     = rem_sh - {1'b0, div_q};
   assign no_borrow = !trial[WIDTH];
   assign rem_nx    = no_borrow ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_nx    = {quo_q[WIDTH-2:0], no_borrow};

   // Fix-up operates on the final step's values so the result can be
   // registered on the same edge that leaves CALC.
   div_sign_fix #(.WIDTH(WIDTH)) u_fix (
      .x_in  (quo_nx),
      .y_in  (rem_nx),
      .neg_x (quo_neg_q),
      .neg_y (rem_neg_q),
      .x_out (quo_fx),
      .y_out (rem_fx)
   );

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      dvd_flg_d  = dvd_flg_q;
      dvs_flg_d  = dvs_flg_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      div_d      = div_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      quo_neg_d  = quo_neg_q;
      rem_neg_d  = rem_neg_q;
      dout_dat_d = dout_dat_q;
      dout_vld_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (dvd_hs) begin
               dvd_d     = s_axis_dividend_tdata;
               dvd_flg_d = 1'b1;
            end
            if (dvs_hs) begin
               dvs_d     = s_axis_divisor_tdata;
               dvs_flg_d = 1'b1;
            end
            if (start) begin
               state_d   = ST_CALC;
               dvd_flg_d = 1'b0;
               dvs_flg_d = 1'b0;
               quo_d     = a_mag;
               rem_d     = '0;
               div_d     = b_mag;
               cnt_d     = CNT_LAST;
               // A zero divisor already drives every quotient bit to one;
               // leaving it un-negated makes it read as -1 in signed mode.
               // The remainder equals |dividend| and takes the dividend sign.
               quo_neg_d = (a_sgn ^ b_sgn) && (b_raw != '0);
               rem_neg_d = a_sgn;
            end
         end

         ST_CALC: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            if (cnt_q == '0) begin
               state_d    = ST_DONE;
               dout_dat_d = `ITER_DIV_DOUT(quo_fx, rem_fx);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_DONE: begin
            // The strobe is registered on the way out of DONE, so it is
            // visible in the first IDLE cycle alongside the raised treadys.
            state_d    = ST_IDLE;
            dout_vld_d = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // flush overrides everything above, including a same-edge handshake.
      if (flush) begin
         state_d    = ST_IDLE;
         dvd_flg_d  = 1'b0;
         dvs_flg_d  = 1'b0;
         dout_vld_d = 1'b0;
         dout_dat_d = dout_dat_q;
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         dvd_flg_q  <= 1'b0;
         dvs_flg_q  <= 1'b0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         div_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         quo_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         dout_dat_q <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dvd_flg_q  <= dvd_flg_d;
         dvs_flg_q  <= dvs_flg_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         div_q      <= div_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         quo_neg_q  <= quo_neg_d;
         rem_neg_q  <= rem_neg_d;
         dout_dat_q <= dout_dat_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign s_axis_dividend_tready = dvd_rdy;
   assign s_axis_divisor_tready  = dvs_rdy;
   assign m_axis_dout_tdata      = dout_dat_q;
   assign m_axis_dout_tvalid     = dout_vld_q;

endmodule

// File: tb/tb_iter_div.sv
// Bench for iter_div: one unsigned and one signed instance share all inputs.
// Latency: results expected WIDTH+1 edges after the last operand handshake.
// Backpressure: bench only offers operands when both instances show tready.

module tb_iter_div;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk;
   logic          resetn;
   logic          flush;
   logic [W-1:0]  dvd_dat, dvs_dat;
   logic          dvd_vld, dvs_vld;
   logic          u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy;
   logic [63:0]   u_dat, s_dat;
   logic          u_vld, s_vld;
   logic [3:0]    rdy_all;

   int n_chk = 0;
   int n_err = 0;

   assign rdy_all = {u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy};

   iter_div #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
      .clk                    (clk),
      .resetn                 (resetn),
      .flush                  (flush),
      .s_axis_dividend_tdata  (dvd_dat),
      .s_axis_dividend_tvalid (dvd_vld),
      .s_axis_dividend_tready (u_dvd_rdy),
      .s_axis_divisor_tdata   (dvs_dat),
      .s_axis_divisor_tvalid  (dvs_vld),
      .s_axis_divisor_tready  (u_dvs_rdy),
      .m_axis_dout_tdata      (u_dat),
      .m_axis_dout_tvalid     (u_vld)
   );

   iter_div #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
      .clk                    (clk),
      .resetn                 (resetn),
      .flush                  (flush),
      .s_axis_dividend_tdata  (dvd_dat),
      .s_axis_dividend_tvalid (dvd_vld),
      .s_axis_dividend_tready (s_dvd_rdy),
      .s_axis_divisor_tdata   (dvs_dat),
      .s_axis_divisor_tvalid  (dvs_vld),
      .s_axis_divisor_tready  (s_dvs_rdy),
      .m_axis_dout_tdata      (s_dat),
      .m_axis_dout_tvalid     (s_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, required to have finished", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic. Truncating signed division in 64 bits makes
   // the overflow case fall out as 2^31, whose low 32 bits are 0x80000000.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {q[31:0], r[31:0]};
      end
      return {a / b, a % b};
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic watch_quiet(input int n, output int seen);
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (u_vld || s_vld) seen++;
      end
   endtask

   // gap = 0: both channels in the same cycle; gap > 0: dividend first, divisor
   // gap cycles later; gap < 0: divisor first. Called #1 after a clock edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int gap,
                         output logic [63:0] ru, output logic [63:0] rs);
      int lat;
      bit busy;
      int ag;
      ag = (gap < 0) ? -gap : gap;
      chk("rdy_pre", 64'(rdy_all), 64'hF);
      if (gap >= 0) begin dvd_vld = 1'b1; dvd_dat = a; end
      if (gap <= 0) begin dvs_vld = 1'b1; dvs_dat = b; end
      @(posedge clk); #1;
      dvd_vld = 1'b0; dvs_vld = 1'b0;
      dvd_dat = $urandom; dvs_dat = $urandom;
      if (gap != 0) begin
         chk("half_rdy", 64'(rdy_all), (gap > 0) ? 64'h5 : 64'hA);
         for (int i = 1; i < ag; i++) begin
            @(posedge clk); #1;
         end
         if (gap > 0) begin dvs_vld = 1'b1; dvs_dat = b; end
         else         begin dvd_vld = 1'b1; dvd_dat = a; end
         @(posedge clk); #1;
         dvd_vld = 1'b0; dvs_vld = 1'b0;
         dvd_dat = $urandom; dvs_dat = $urandom;
      end
      lat  = 0;
      busy = 1'b0;
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         @(posedge clk); #1;
         dvd_dat = $urandom; dvs_dat = $urandom;
         if (u_vld || s_vld) lat = k;
         else if (rdy_all != 4'h0) busy = 1'b1;
      end
      chk("latency", 64'(lat), 64'(LAT));
      chk("busy_rdy", 64'(busy), 64'h0);
      chk("vld_pair", {62'h0, u_vld, s_vld}, 64'h3);
      ru = u_dat;
      rs = s_dat;
      chk("res_u", ru, ref_div(a, b, 1'b0));
      chk("res_s", rs, ref_div(a, b, 1'b1));
      chk("rdy_post", 64'(rdy_all), 64'hF);
   endtask

   initial begin
      logic [63:0] ru, rs, prev;
      int seen;
      resetn  = 1'b0;
      flush   = 1'b0;
      dvd_vld = 1'b0;
      dvs_vld = 1'b0;
      dvd_dat = '0;
      dvs_dat = '0;

      #2;
      chk("rst_rdy", 64'(rdy_all), 64'hF);
      chk("rst_vld", {62'h0, u_vld, s_vld}, 64'h0);
      chk("rst_dat", u_dat | s_dat, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_op(32'd100, 32'd7, 0, ru, rs);
      chk("u_100_7", ru, 64'h0000000E_00000002);
      prev = u_dat;
      @(posedge clk); #1;
      chk("vld_drop", {62'h0, u_vld, s_vld}, 64'h0);
      chk("dat_hold", u_dat, prev);

      run_op(32'hFFFF_FFF9, 32'd2, 5, ru, rs);
      chk("s_m7_2", rs, 64'hFFFFFFFD_FFFFFFFF);
      run_op(32'd7, 32'hFFFF_FFFE, 0, ru, rs);
      chk("s_7_m2", rs, 64'hFFFFFFFD_00000001);
      run_op(32'h1234_5678, 32'd0, 0, ru, rs);
      chk("u_div0", ru, 64'hFFFFFFFF_12345678);
      run_op(32'hFFFF_FFFB, 32'd0, -2, ru, rs);
      chk("s_div0", rs, 64'hFFFFFFFF_FFFFFFFB);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, ru, rs);
      chk("s_ovf", rs, 64'h80000000_00000000);
      chk("u_ovf", ru, 64'h00000000_80000000);

      // Flush during CALC.
      prev = u_dat;
      dvd_vld = 1'b1; dvd_dat = 32'd50;
      dvs_vld = 1'b1; dvs_dat = 32'd5;
      @(posedge clk); #1;
      dvd_vld = 1'b0; dvs_vld = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_rdy", 64'(rdy_all), 64'hF);
      chk("flush_vld", {62'h0, u_vld, s_vld}, 64'h0);
      watch_quiet(40, seen);
      chk("flush_quiet", 64'(seen), 64'h0);
      chk("flush_dat", u_dat, prev);
      run_op(32'd9, 32'd3, 0, ru, rs);
      chk("after_flush", ru, 64'h00000003_00000000);

      // Flush overlapping a dividend-only handshake: nothing may be captured.
      dvd_vld = 1'b1; dvd_dat = 32'd77;
      flush   = 1'b1;
      @(posedge clk); #1;
      dvd_vld = 1'b0;
      flush   = 1'b0;
      chk("flush_hs_rdy", 64'(rdy_all), 64'hF);
      dvs_vld = 1'b1; dvs_dat = 32'd7;
      @(posedge clk); #1;
      dvs_vld = 1'b0;
      watch_quiet(40, seen);
      chk("flush_hs_quiet", 64'(seen), 64'h0);
      chk("dvs_only_rdy", 64'(rdy_all), 64'hA);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      run_op(32'd21, 32'd4, 0, ru, rs);

      // Asynchronous reset mid-CALC, checked before the next clock edge.
      dvd_vld = 1'b1; dvd_dat = 32'd1000;
      dvs_vld = 1'b1; dvs_dat = 32'd3;
      @(posedge clk); #1;
      dvd_vld = 1'b0; dvs_vld = 1'b0;
      repeat (15) begin @(posedge clk); #1; end
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_rdy", 64'(rdy_all), 64'hF);
      chk("arst_vld", {62'h0, u_vld, s_vld}, 64'h0);
      chk("arst_dat", u_dat | s_dat, 64'h0);
      @(posedge clk); #1;
      resetn = 1'b1;

      // Back-to-back randomized operations.
      for (int n = 0; n < 30; n++) begin
         run_op(pick_operand(), pick_operand(), int'($urandom_range(0, 6)) - 3, ru, rs);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
